// File: rtl/scroll_position_gen.sv
// Purpose : multi-layer raster scroll position generator (per-layer H/V scroll counters, flip-aware).
// Latency : writes land 1 clk after wr_en; H reload 1 clk after hblank rises; V step 1 clk after hsync falls.
// Backpressure: none; every write strobe is accepted in its cycle (out-of-range layer writes are dropped).
//
// Ports:
//   clk, reset       system clock, synchronous active-high reset
//   ce               pixel clock enable (gates horizontal counting)
//   hblank, vblank   blanking intervals; hsync active-high horizontal sync
//   flip             1 = counters run backwards (cocktail player 2)
//   wr_en/addr/data  CPU scroll-load strobe; addr bit0 selects H(0)/V(1), upper bits select layer
//   hpos             per-layer H scroll position, layer n at [n*HW +: HW]
//   vpos             per-layer V scroll position clamped to [VMIN, VMAX], layer n at [n*VW +: VW]
module scroll_position_gen #(
  parameter int            LAYERS  = 1,
  parameter int            HW      = 8,
  parameter int            VW      = 8,
  parameter logic [VW-1:0] VMIN    = 8'h18,
  parameter logic [VW-1:0] VMAX    = 8'hFF,
  parameter logic [VW-1:0] VINIT   = 8'h18,
  parameter int            HRELOAD = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                ce,
  input  logic                                hblank,
  input  logic                                vblank,
  input  logic                                hsync,
  input  logic                                flip,
  input  logic                                wr_en,
  input  logic [$clog2(LAYERS):0]             wr_addr,
  input  logic [((HW > VW) ? HW : VW)-1:0]    wr_data,
  output logic [LAYERS*HW-1:0]                hpos,
  output logic [LAYERS*VW-1:0]                vpos
);

  localparam logic [HW-1:0] H_ONE = 1;
  localparam logic [VW-1:0] V_ONE = 1;

  // Registered copies of the raster strobes for edge detection.
  logic hblank_d;
  logic hsync_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      hblank_d <= 1'b0;
      hsync_d  <= 1'b0;
    end else begin
      hblank_d <= hblank;
      hsync_d  <= hsync;
    end
  end

  logic hblank_rise;
  logic hsync_fall;
  logic h_count_en;

  assign hblank_rise = hblank & ~hblank_d;
  assign hsync_fall  = hsync_d & ~hsync;
  assign h_count_en  = ce & ~vblank & ~hblank;

  // Write decode. The layer field can encode values beyond LAYERS when
  // LAYERS is not a power of two; those writes are dropped.
  int   wr_layer;
  logic wr_ok;

  assign wr_layer = int'(wr_addr >> 1);
  assign wr_ok    = wr_en && (wr_layer < LAYERS);

  for (genvar l = 0; l < LAYERS; l++) begin : g_layer
    logic [HW-1:0] h_cnt;
    logic [HW-1:0] h_shd;
    logic [VW-1:0] v_cnt;
    logic [VW-1:0] v_shd;
    logic [VW-1:0] v_clamp;
    logic          sel;
    logic          h_wr;
    logic          v_wr;

    assign sel  = wr_ok && (wr_layer == l);
    assign h_wr = sel & ~wr_addr[0];
    assign v_wr = sel &  wr_addr[0];

    // Horizontal: direct write beats reload beats count. In reload mode a
    // write and a reload in the same clk both act: the counter takes the old
    // shadow, the new shadow value is used on the following line.
    always_ff @(posedge clk) begin
      if (reset) begin
        h_cnt <= '0;
        h_shd <= '0;
      end else begin
        if ((HRELOAD == 0) && h_wr) begin
          h_cnt <= wr_data[HW-1:0];
        end else if ((HRELOAD != 0) && hblank_rise) begin
          h_cnt <= h_shd;
        end else if (h_count_en) begin
          h_cnt <= flip ? (h_cnt - H_ONE) : (h_cnt + H_ONE);
        end

        if ((HRELOAD != 0) && h_wr) begin
          h_shd <= wr_data[HW-1:0];
        end
      end
    end

    // Vertical: the shadow is copied continuously through vblank, so a write
    // outside vblank only becomes visible at the next frame.
    always_ff @(posedge clk) begin
      if (reset) begin
        v_shd <= VINIT;
        v_cnt <= '0;
      end else begin
        if (v_wr) begin
          v_shd <= wr_data[VW-1:0];
        end

        if (vblank) begin
          v_cnt <= v_shd;
        end else if (hsync_fall) begin
          v_cnt <= flip ? (v_cnt - V_ONE) : (v_cnt + V_ONE);
        end
      end
    end

    // The counter itself keeps running outside the window; only the output
    // is clamped, so it re-enters the window at the correct line.
    always_comb begin
      v_clamp = v_cnt;
      if (v_cnt < VMIN) begin
        v_clamp = VMIN;
      end else if (v_cnt > VMAX) begin
        v_clamp = VMAX;
      end
    end

    assign hpos[l*HW +: HW] = h_cnt;
    assign vpos[l*VW +: VW] = v_clamp;
  end

endmodule
